// File: rtl/cv32e40s_pkg.sv
// Shared types and default constants for the alert receiver slice.
// Holds the receiver FSM encoding and parameter defaults.
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    ALERT_RX_IDLE      = 2'b00,
    ALERT_RX_NMI_WAIT  = 2'b01,
    ALERT_RX_RESET_REQ = 2'b10
  } alert_rx_state_e;

  localparam int unsigned ALERT_MINOR_THRESHOLD = 4;
  localparam int unsigned ALERT_LEAK_PERIOD     = 1024;
  localparam int unsigned ALERT_CNT_W           = 8;
  localparam int unsigned ALERT_NMI_TIMEOUT     = 64;

endpackage

// File: rtl/cv32e40s_alert_leaky_cnt.sv
// Saturating minor-alert counter drained by a free-running leak timer.
// clear zeroes count and timer, flush zeroes only the count.
module cv32e40s_alert_leaky_cnt
  import cv32e40s_pkg::*;
#(
  parameter int unsigned CNT_W       = ALERT_CNT_W,
  parameter int unsigned LEAK_PERIOD = ALERT_LEAK_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  input  logic             flush_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned LW = $clog2(LEAK_PERIOD);
  localparam logic [LW-1:0] LAST = LW'(LEAK_PERIOD - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    tmr_q, tmr_d;
  logic             leak;

  assign leak = (tmr_q == LAST);

  always_comb begin
    tmr_d = leak ? '0 : tmr_q + LW'(1);
    cnt_d = cnt_q;
    if (freeze_i) begin
      tmr_d = tmr_q;
    end else if (clear_i) begin
      tmr_d = '0;
      cnt_d = '0;
    end else if (flush_i) begin
      cnt_d = '0;
    end else if (inc_i && !leak) begin
      if (cnt_q != CMAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc_i && leak) begin
      // an increment landing on a wrap cancels the leak
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40s_alert_receiver.sv
// Alert receiver: leaky minor-alert bucket with NMI then reset escalation.
// All outputs come straight from flops.
module cv32e40s_alert_receiver
  import cv32e40s_pkg::*;
#(
  parameter int unsigned MINOR_THRESHOLD = ALERT_MINOR_THRESHOLD,
  parameter int unsigned LEAK_PERIOD     = ALERT_LEAK_PERIOD,
  parameter int unsigned CNT_W           = ALERT_CNT_W,
  parameter int unsigned NMI_TIMEOUT     = ALERT_NMI_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alert_minor_i,
  input  logic             alert_major_i,
  input  logic             clear_i,
  input  logic             nmi_ack_i,
  output logic             nmi_req_o,
  output logic             reset_req_o,
  output logic [CNT_W-1:0] minor_cnt_o,
  output logic             escalated_o,
  output logic [1:0]       state_o
);

  localparam int unsigned NTW = $clog2(NMI_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] THR = CNT_W'(MINOR_THRESHOLD);
  localparam logic [NTW-1:0] TO_LAST = NTW'(NMI_TIMEOUT - 1);

  alert_rx_state_e  state_q, state_d;
  logic [NTW-1:0]   ntmr_q, ntmr_d;
  logic             esc_q, esc_d;
  logic             nmi_q, rreq_q;
  logic             is_idle, is_wait, is_rreq;
  logic             trig, esc_cond, ack_ok;
  logic [CNT_W-1:0] cnt;

  assign is_idle  = (state_q == ALERT_RX_IDLE);
  assign is_wait  = (state_q == ALERT_RX_NMI_WAIT);
  assign is_rreq  = (state_q == ALERT_RX_RESET_REQ);
  assign trig     = alert_major_i | (cnt >= THR);
  assign esc_cond = alert_major_i | (ntmr_q == TO_LAST);
  assign ack_ok   = is_wait & nmi_ack_i & ~esc_cond;

  cv32e40s_alert_leaky_cnt #(
    .CNT_W       (CNT_W),
    .LEAK_PERIOD (LEAK_PERIOD)
  ) u_leaky_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (alert_minor_i),
    .clear_i  (is_idle & clear_i),
    .flush_i  (ack_ok),
    .freeze_i (is_rreq),
    .cnt_o    (cnt)
  );

  always_comb begin
    state_d = state_q;
    ntmr_d  = ntmr_q;
    esc_d   = esc_q;
    unique case (state_q)
      ALERT_RX_IDLE: begin
        if (clear_i) esc_d = 1'b0;
        // a trigger still escalates even when clear lands with it
        if (trig) begin
          state_d = ALERT_RX_NMI_WAIT;
          ntmr_d  = '0;
          esc_d   = 1'b1;
        end
      end
      ALERT_RX_NMI_WAIT: begin
        if (esc_cond) begin
          state_d = ALERT_RX_RESET_REQ;
        end else if (nmi_ack_i) begin
          state_d = ALERT_RX_IDLE;
        end else begin
          ntmr_d = ntmr_q + NTW'(1);
        end
      end
      ALERT_RX_RESET_REQ: begin
        state_d = ALERT_RX_RESET_REQ;
      end
      default: begin
        state_d = ALERT_RX_RESET_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALERT_RX_IDLE;
      ntmr_q  <= '0;
      esc_q   <= 1'b0;
      nmi_q   <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ntmr_q  <= ntmr_d;
      esc_q   <= esc_d;
      nmi_q   <= (state_d == ALERT_RX_NMI_WAIT);
      rreq_q  <= (state_d == ALERT_RX_RESET_REQ);
    end
  end

  assign nmi_req_o   = nmi_q;
  assign reset_req_o = rreq_q;
  assign minor_cnt_o = cnt;
  assign escalated_o = esc_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cv32e40s_alert_receiver.sv
// Scoreboard bench for the alert receiver, two parameter sets side by side.
// Directed scenarios followed by random stimulus against a rule-level model.
module tb_cv32e40s_alert_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mi = 1'b0, ma = 1'b0, clr = 1'b0, ack = 1'b0;

  logic       a_nmi, a_rr, a_esc;
  logic [7:0] a_cnt;
  logic [1:0] a_state;
  logic       b_nmi, b_rr, b_esc;
  logic [2:0] b_cnt;
  logic [1:0] b_state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cv32e40s_alert_receiver #(
    .MINOR_THRESHOLD (4),
    .LEAK_PERIOD     (1024),
    .CNT_W           (8),
    .NMI_TIMEOUT     (64)
  ) u_a (
    .clk           (clk),
    .rst           (rst),
    .alert_minor_i (mi),
    .alert_major_i (ma),
    .clear_i       (clr),
    .nmi_ack_i     (ack),
    .nmi_req_o     (a_nmi),
    .reset_req_o   (a_rr),
    .minor_cnt_o   (a_cnt),
    .escalated_o   (a_esc),
    .state_o       (a_state)
  );

  cv32e40s_alert_receiver #(
    .MINOR_THRESHOLD (7),
    .LEAK_PERIOD     (8),
    .CNT_W           (3),
    .NMI_TIMEOUT     (5)
  ) u_b (
    .clk           (clk),
    .rst           (rst),
    .alert_minor_i (mi),
    .alert_major_i (ma),
    .clear_i       (clr),
    .nmi_ack_i     (ack),
    .nmi_req_o     (b_nmi),
    .reset_req_o   (b_rr),
    .minor_cnt_o   (b_cnt),
    .escalated_o   (b_esc),
    .state_o       (b_state)
  );

  typedef struct {
    int st;
    int cnt;
    int lt;
    int nt;
    bit esc;
  } mdl_t;

  typedef struct {
    int thr;
    int maxc;
    int lp;
    int to;
  } prm_t;

  typedef struct {
    logic [12:0] a;
    logic [10:0] b;
  } exp_t;

  prm_t pa = '{thr: 4, maxc: 255, lp: 1024, to: 64};
  prm_t pb = '{thr: 7, maxc: 7, lp: 8, to: 5};
  mdl_t mda = '{0, 0, 0, 0, 1'b0};
  mdl_t mdb = '{0, 0, 0, 0, 1'b0};
  exp_t sb[$];

  // st: 0 idle, 1 waiting for NMI ack, 2 reset requested
  function automatic mdl_t step(mdl_t m, prm_t p,
                                bit r, bit inc, bit maj,
                                bit cl, bit ak);
    mdl_t n;
    bit leak;
    n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 1'b0};
      return n;
    end
    if (m.st == 2) return n;
    leak = (m.lt == p.lp - 1);
    n.lt = leak ? 0 : m.lt + 1;
    if (inc && leak) n.cnt = m.cnt;
    else if (inc) n.cnt = (m.cnt < p.maxc) ? m.cnt + 1 : m.cnt;
    else if (leak && m.cnt > 0) n.cnt = m.cnt - 1;
    if (m.st == 0) begin
      if (cl) begin
        n.cnt = 0;
        n.lt = 0;
        n.esc = 1'b0;
      end
      if (maj || m.cnt >= p.thr) begin
        n.st = 1;
        n.nt = 0;
        n.esc = 1'b1;
      end
    end else begin
      if (maj || m.nt == p.to - 1) begin
        n.st = 2;
      end else if (ak) begin
        n.st = 0;
        n.cnt = 0;
      end else begin
        n.nt = m.nt + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [12:0] pack_a(mdl_t m);
    logic [1:0] s;
    s = 2'(m.st);
    return {s, m.esc, m.st == 2, m.st == 1, 8'(m.cnt)};
  endfunction

  function automatic logic [10:0] pack_b(mdl_t m);
    logic [1:0] s;
    s = 2'(m.st);
    return {s, m.esc, m.st == 2, m.st == 1, 3'(m.cnt)};
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(bit r, bit inc, bit maj, bit cl, bit ak);
    exp_t e;
    @(negedge clk);
    rst = r;
    mi = inc;
    ma = maj;
    clr = cl;
    ack = ak;
    mda = step(mda, pa, r, inc, maj, cl, ak);
    mdb = step(mdb, pb, r, inc, maj, cl, ak);
    e.a = pack_a(mda);
    e.b = pack_b(mdb);
    sb.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("scoreboard_a",
              32'({a_state, a_esc, a_rr, a_nmi, a_cnt}), 32'(e.a));
        check("scoreboard_b",
              32'({b_state, b_esc, b_rr, b_nmi, b_cnt}), 32'(e.b));
      end
    end
  end

  initial begin : driver
    cyc(1, 0, 0, 0, 0);
    after_edge;
    check("reset_a", 32'({a_state, a_esc, a_rr, a_nmi, a_cnt}), 32'(0));
    check("reset_b", 32'({b_state, b_esc, b_rr, b_nmi, b_cnt}), 32'(0));

    for (int p = 0; p < 4; p++) begin
      cyc(0, 1, 0, 0, 0);
      if (p < 3) idle(1);
    end
    after_edge;
    check("thr_cnt", 32'(a_cnt), 32'(4));
    check("thr_still_idle", 32'(a_state), 32'(0));
    idle(1);
    after_edge;
    check("thr_nmi", 32'({a_state, a_nmi, a_esc}), 32'(4'b0111));

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    after_edge;
    check("major_enter", 32'({a_state, a_nmi}), 32'(3'b011));
    idle(9);
    cyc(0, 0, 0, 0, 1);
    after_edge;
    check("ack_idle", 32'({a_state, a_nmi, a_cnt, a_esc}), 32'(12'h001));
    cyc(0, 0, 0, 1, 0);
    after_edge;
    check("clear_esc", 32'(a_esc), 32'(0));

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    after_edge;
    check("to_enter", 32'(a_state), 32'(1));
    idle(63);
    after_edge;
    check("to_early", 32'(a_rr), 32'(0));
    idle(1);
    after_edge;
    check("to_fire", 32'({a_rr, a_nmi, a_state}), 32'(4'b1010));
    repeat (1000) begin
      cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    after_edge;
    check("to_hold", 32'({a_rr, a_state, a_esc}), 32'(4'b1101));
    cyc(1, 0, 0, 0, 0);
    after_edge;
    check("rst_release", 32'({a_state, a_esc, a_rr, a_nmi, a_cnt}), 32'(0));

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    idle(5);
    cyc(0, 0, 1, 0, 1);
    after_edge;
    check("collision", 32'({a_state, a_rr}), 32'(3'b101));

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(1);
    cyc(0, 1, 0, 0, 0);
    after_edge;
    check("leak_start", 32'(a_cnt), 32'(2));
    idle(1097);
    after_edge;
    check("leak_one", 32'(a_cnt), 32'(1));
    idle(1000);
    after_edge;
    check("leak_zero", 32'(a_cnt), 32'(0));

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    while (mda.lt != 1023) idle(1);
    cyc(0, 1, 0, 0, 0);
    after_edge;
    check("leak_vs_inc", 32'(a_cnt), 32'(1));

    cyc(1, 0, 0, 0, 0);
    repeat (20) cyc(0, 1, 0, 0, 0);
    after_edge;
    check("sat_b", 32'(b_cnt), 32'(7));
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    after_edge;
    check("clr_beats_inc_b", 32'(b_cnt), 32'(0));
    check("clr_beats_inc_a", 32'(a_cnt), 32'(0));

    repeat (20000) begin
      cyc($urandom_range(999) < 4, $urandom_range(99) < 35,
          $urandom_range(99) < 1, $urandom_range(99) < 3,
          $urandom_range(99) < 6);
    end

    after_edge;
    repeat (2) @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_alert_receiver.md
# cv32e40s_alert_receiver

Consumer of the core's registered alert outputs. The block accumulates minor alerts in a leaky-bucket counter and escalates on any major alert or on minor-alert overflow. Escalation first raises an NMI request to the system; if that request goes unacknowledged or a further major alert arrives, the block raises a terminal reset request. It sits in the SoC wrapper beside the core, in the core clock domain, with no synchronizers.

## Interface
Parameters:
- `MINOR_THRESHOLD`, 4: minor count at or above which escalation triggers; legal range 1..2^CNT_W-1.
- `LEAK_PERIOD`, 1024: cycles between leak decrements; must be ≥2.
- `CNT_W`, 8: minor counter width.
- `NMI_TIMEOUT`, 64: cycles to wait for `nmi_ack_i` before the reset request; must be ≥1.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `alert_minor_i`  in  1  minor alert from the core; level, sampled every cycle.
- `alert_major_i`  in  1  major alert from the core; level, sampled every cycle.
- `clear_i`  in  1  software clear; honoured only in IDLE.
- `nmi_ack_i`  in  1  system acknowledge of the NMI; single-cycle pulse.
- `nmi_req_o`  out  1  NMI request; high throughout NMI_WAIT.
- `reset_req_o`  out  1  reset request; high in RESET_REQ, released only by `rst`.
- `minor_cnt_o`  out  CNT_W  current minor count.
- `escalated_o`  out  1  sticky flag, set when an escalation has occurred.
- `state_o`  out  2  FSM state: IDLE=00, NMI_WAIT=01, RESET_REQ=10; the encoding 11 is unused.

## Operation
- Reset values: all outputs 0, FSM in IDLE, leak timer and NMI timer at 0.
- Minor counter:
  - Increments by 1 in every cycle `alert_minor_i`=1; saturates at 2^CNT_W-1 with no wrap.
  - Leak timer counts 0..LEAK_PERIOD-1 and wraps continuously. On wrap, the counter decrements if it is nonzero.
  - Increment and leak in the same cycle leave the counter unchanged. Leak at count 0 has no effect.
- Escalation trigger, evaluated in IDLE only: `alert_major_i`=1, or `minor_cnt_o` ≥ MINOR_THRESHOLD.
- FSM:
  - IDLE → NMI_WAIT on trigger. Entering NMI_WAIT sets `escalated_o` and loads the NMI timer with 0.
  - NMI_WAIT → RESET_REQ when `alert_major_i`=1 or the NMI timer reaches NMI_TIMEOUT-1.
  - NMI_WAIT → IDLE on `nmi_ack_i`=1 with no escalation condition present. On this transition the minor counter clears to 0.
  - If ack and an escalation condition occur in the same cycle, RESET_REQ wins (fail-secure).
  - RESET_REQ is terminal. All inputs are ignored there except `rst`. The minor counter freezes.
- Minor alerts continue to count in NMI_WAIT. A threshold crossing there causes no additional action.
- `clear_i` in IDLE:
  - Zeroes the minor counter and leak timer, and clears `escalated_o`.
  - Beats a same-cycle increment.
  - Does not suppress a same-cycle trigger, so the FSM still enters NMI_WAIT.
- `clear_i` outside IDLE is ignored.
- `nmi_ack_i` outside NMI_WAIT is ignored.
- `rst` asserted in any state returns everything to reset values on the next edge, including a pending reset request.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Trigger sampled at edge N → `nmi_req_o`, `escalated_o` and `state_o`=01 are visible after edge N. With the core's output flop, core event to NMI is 2 cycles.
- `minor_cnt_o` reflects the increment one cycle after `alert_minor_i` is sampled. A threshold trigger caused by that increment enters NMI_WAIT one cycle later still.
- NMI timeout: entering NMI_WAIT at edge E with no ack → `reset_req_o` asserts at edge E+NMI_TIMEOUT.
- Ack sampled at edge A → `nmi_req_o`=0 and `minor_cnt_o`=0 after edge A.

## Structure
- Shared package (`cv32e40s_pkg`) holds:
  - the `alert_rx_state_e` enum: IDLE, NMI_WAIT, RESET_REQ, 2 bits;
  - default parameter constants.
- Sub-module `cv32e40s_alert_leaky_cnt` implements the saturating counter plus leak timer, with inputs inc, clear and freeze. The FSM stays in the top module.
- The NMI timer width is $clog2(NMI_TIMEOUT+1). The leak timer width is $clog2(LEAK_PERIOD).

## Test plan
- **Minor threshold:** defaults; pulse `alert_minor_i` for 4 separate cycles, spaced under LEAK_PERIOD apart → `minor_cnt_o`=4, then `state_o`=01 one cycle later with `nmi_req_o`=1 and `escalated_o`=1.
- **Leak:** 2 minor pulses, then idle for 2×LEAK_PERIOD cycles → count drops 2→1→0 at the leak wraps and stays 0. Separately, an increment coinciding with a leak wrap → count unchanged.
- **Major then ack:** `alert_major_i`=1 for 1 cycle; ack 10 cycles later → NMI_WAIT for 10 cycles, then IDLE with count 0 and `escalated_o` still 1. Then `clear_i` → `escalated_o`=0.
- **Timeout:** major alert, no ack → `reset_req_o`=1 exactly 64 cycles after entering NMI_WAIT and held for 1000 cycles. `clear_i` has no effect. `rst` for 1 cycle → all outputs 0.
- **Collision:** in NMI_WAIT, assert `alert_major_i` and `nmi_ack_i` in the same cycle → RESET_REQ.
- **Saturation and clear priority (CNT_W=3, MINOR_THRESHOLD=7):** hold `alert_minor_i` for 20 cycles → count saturates at 7 with no wrap. In IDLE, `clear_i` together with `alert_minor_i` → count 0.
